// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, jr, branch flush, mul/div occupancy.
// Optional stall performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             JRegControl,
  input  logic             BranchTaken_MEM,
  input  logic             MulDivStart,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] LoadStallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MulDivCnt,
`endif
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             MulDivBusy,
  output logic             MulDivAbort
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;
  logic       lu_stall;

  assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MulDivBusy  = 1'b0;
    MulDivAbort = 1'b0;
    lu_stall    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (!Rst) begin
      // Hold the front end and bubble everything; an in-flight mul/div dies silently.
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      state_d     = RUN;
      cnt_d       = 4'd0;
    end else if (BranchTaken_MEM) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      if (state_q == MD_BUSY) begin
        MulDivBusy  = 1'b1;
        MulDivAbort = 1'b1;
      end
      state_d = RUN;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
            lu_stall   = 1'b1;
          end else if (JRegControl) begin
            IFID_Flush = 1'b1;
          end
          // The mul/div is already in EX, so it starts even under a load-use stall.
          if (MulDivStart) begin
            state_d = MD_BUSY;
            cnt_d   = LAT_M1;
          end
        end
        MD_BUSY: begin
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Write  = 1'b0;
          EXMEM_Flush = 1'b1;
          MulDivBusy  = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      LoadStallCnt <= '0;
      FlushCnt     <= '0;
      MulDivCnt    <= '0;
    end else begin
      LoadStallCnt <= sat_inc(LoadStallCnt, lu_stall);
      FlushCnt     <= sat_inc(FlushCnt, BranchTaken_MEM);
      MulDivCnt    <= sat_inc(MulDivCnt, MulDivBusy);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl; expected output vectors are hand-computed constants.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IFID_UsesRt, IDEX_MemRead, JRegControl, BranchTaken_MEM, MulDivStart;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Flush;
  logic       MulDivBusy, MulDivAbort;
`ifdef HAZARD_PERF_EN
  logic [15:0] LoadStallCnt, FlushCnt, MulDivCnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Vector order: PCWrite IFID_Write IFID_Flush IDEX_Write IDEX_Flush EXMEM_Flush MulDivBusy MulDivAbort
  localparam logic [7:0] V_DEF   = 8'b1101_0000;
  localparam logic [7:0] V_RST   = 8'b0010_1100;
  localparam logic [7:0] V_LU    = 8'b0001_1000;
  localparam logic [7:0] V_JR    = 8'b1111_0000;
  localparam logic [7:0] V_BUSY  = 8'b0000_0110;
  localparam logic [7:0] V_BR    = 8'b1111_1100;
  localparam logic [7:0] V_BR_MD = 8'b1111_1111;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .JRegControl(JRegControl), .BranchTaken_MEM(BranchTaken_MEM), .MulDivStart(MulDivStart),
`ifdef HAZARD_PERF_EN
    .LoadStallCnt(LoadStallCnt), .FlushCnt(FlushCnt), .MulDivCnt(MulDivCnt),
`endif
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .MulDivBusy(MulDivBusy), .MulDivAbort(MulDivAbort)
  );

  wire [7:0] outs = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
                     IDEX_Flush, EXMEM_Flush, MulDivBusy, MulDivAbort};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    JRegControl = 1'b0; BranchTaken_MEM = 1'b0; MulDivStart = 1'b0;
  endtask

  // Check the outputs for the current input set mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [7:0] exp);
    @(negedge Clk);
    check(tag, 32'(outs), 32'(exp));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle();
    Rst = 1'b0;
    step("reset0", V_RST);
    step("reset1", V_RST);
    Rst = 1'b1;
    step("idle", V_DEF);

    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
    step("lu_rs", V_LU);
    idle();
    step("lu_rs_after", V_DEF);

    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    step("lu_r0", V_DEF);

    idle();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd7; IFID_Rt = 5'd7; IFID_Rs = 5'd3;
    step("rt_unused", V_DEF);
    IFID_UsesRt = 1'b1;
    step("rt_used", V_LU);
    idle();
    step("rt_after", V_DEF);

    JRegControl = 1'b1;
    step("jr", V_JR);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9;
    step("lu_jr", V_LU);
    IDEX_MemRead = 1'b0;
    step("jr_reeval", V_JR);
    idle();

    MulDivStart = 1'b1;
    step("md_start", V_DEF);
    MulDivStart = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("md_busy%0d", i), V_BUSY);
    step("md_done", V_DEF);

    MulDivStart = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4;
    step("md_lu_start", V_LU);
    idle();
    for (int i = 0; i < 3; i++) step($sformatf("md_lu_busy%0d", i), V_BUSY);
    step("md_lu_done", V_DEF);

    MulDivStart = 1'b1;
    step("md_br_start", V_DEF);
    MulDivStart = 1'b0;
    step("md_br_busy0", V_BUSY);
    BranchTaken_MEM = 1'b1;
    step("md_br_abort", V_BR_MD);
    BranchTaken_MEM = 1'b0;
    step("md_br_after", V_DEF);

    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd6; IFID_Rs = 5'd6;
    JRegControl = 1'b1; BranchTaken_MEM = 1'b1;
    step("br_lu_jr", V_BR);
    idle();

    MulDivStart = 1'b1; BranchTaken_MEM = 1'b1;
    step("br_start", V_BR);
    idle();
    step("br_start_after", V_DEF);

`ifdef HAZARD_PERF_EN
    check("cnt_lu", 32'(LoadStallCnt), 32'd4);
    check("cnt_flush", 32'(FlushCnt), 32'd3);
    check("cnt_md", 32'(MulDivCnt), 32'd8);
`endif

    MulDivStart = 1'b1;
    step("rst_md_start", V_DEF);
    MulDivStart = 1'b0;
    step("rst_md_busy0", V_BUSY);
    Rst = 1'b0;
    step("rst_md0", V_RST);
    step("rst_md1", V_RST);
    Rst = 1'b1;
    step("rst_md_after", V_DEF);
    step("rst_md_idle", V_DEF);

`ifdef HAZARD_PERF_EN
    check("cnt_lu_rst", 32'(LoadStallCnt), 32'd0);
    check("cnt_flush_rst", 32'(FlushCnt), 32'd0);
    check("cnt_md_rst", 32'(MulDivCnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
